// File: rtl/gate_truth_table_identifier.sv
// Drives a 2-input gate under test through all four input vectors, captures its
// truth table and decodes it into a gate code.
module gate_truth_table_identifier #(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_in,
  input  logic       dut_in,
  output logic       a_out,
  output logic       b_out,
  output logic       busy_out,
  output logic       done_out,
  output logic       valid_out,
  output logic [2:0] gate_code_out,
  output logic [3:0] tt_out
);

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

  state_t           state, state_nxt;
  logic [1:0]       idx;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       tt_cap;
  logic [3:0]       tt_final;
  logic [3:0]       dec;

  // Returns {valid, code}; unknown tables decode to {0, 0}.
  function automatic logic [3:0] decode(input logic [3:0] tt);
    case (tt)
      4'b0011: decode = 4'b1000;
      4'b1100: decode = 4'b1001;
      4'b1000: decode = 4'b1010;
      4'b1110: decode = 4'b1011;
      4'b0111: decode = 4'b1100;
      4'b0001: decode = 4'b1101;
      4'b0110: decode = 4'b1110;
      4'b1001: decode = 4'b1111;
      default: decode = 4'b0000;
    endcase
  endfunction

  // The last vector's sample completes the table on the edge that enters DONE.
  assign tt_final = {dut_in, tt_cap[2:0]};
  assign dec      = decode(tt_final);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start_in) state_nxt = (SETTLE_CYCLES == 0) ? SAMPLE : DRIVE;
      end
      DRIVE: begin
        if (cnt == CNT_W'(SETTLE_CYCLES - 1)) state_nxt = SAMPLE;
      end
      SAMPLE: begin
        if (idx == 2'd3)             state_nxt = DONE;
        else if (SETTLE_CYCLES == 0) state_nxt = SAMPLE;
        else                         state_nxt = DRIVE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      idx           <= 2'd0;
      cnt           <= '0;
      tt_cap        <= 4'd0;
      tt_out        <= 4'd0;
      gate_code_out <= 3'd0;
      valid_out     <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          idx    <= 2'd0;
          cnt    <= '0;
          tt_cap <= 4'd0;
        end
        DRIVE: cnt <= cnt + 1'b1;
        SAMPLE: begin
          tt_cap[idx] <= dut_in;
          idx         <= idx + 2'd1;
          cnt         <= '0;
          if (idx == 2'd3) begin
            tt_out        <= tt_final;
            gate_code_out <= dec[2:0];
            valid_out     <= dec[3];
          end
        end
        default: cnt <= '0;
      endcase
    end
  end

  assign busy_out = (state == DRIVE) || (state == SAMPLE);
  assign done_out = (state == DONE);
  assign a_out    = busy_out & idx[1];
  assign b_out    = busy_out & idx[0];

endmodule

// File: tb/tb_gate_truth_table_identifier.sv
// Bench for gate_truth_table_identifier: one instance with the default settle
// time and one with SETTLE_CYCLES=0, each fed by a selectable gate model.
module tb_gate_truth_table_identifier;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start1 = 1'b0, start0 = 1'b0;
  logic dut_in1, dut_in0;
  logic a1, b1, busy1, done1, valid1;
  logic a0, b0, busy0, done0, valid0;
  logic [2:0] code1, code0;
  logic [3:0] tt1, tt0;

  int gsel1 = 2, gsel0 = 6;
  logic [3:0] rnd_tt = 4'd0;
  int msel = 1;
  int total = 0, bad = 0;

  logic a_m, b_m, busy_m, done_m, valid_m;
  logic [2:0] code_m;
  logic [3:0] tt_m;

  logic [3:0] known [8] = '{4'b0011, 4'b1100, 4'b1000, 4'b1110,
                            4'b0111, 4'b0001, 4'b0110, 4'b1001};

  always #5 clk = ~clk;

  // Gate models: 0..7 the known gates, 8 constant 0, 9 constant 1, else a random table.
  function automatic logic gate_fn(input int g, input logic a, input logic b,
                                   input logic [3:0] rt);
    case (g)
      0: gate_fn = ~a;
      1: gate_fn = a;
      2: gate_fn = a & b;
      3: gate_fn = a | b;
      4: gate_fn = ~(a & b);
      5: gate_fn = ~(a | b);
      6: gate_fn = a ^ b;
      7: gate_fn = ~(a ^ b);
      8: gate_fn = 1'b0;
      9: gate_fn = 1'b1;
      default: gate_fn = rt[{a, b}];
    endcase
  endfunction

  assign dut_in1 = gate_fn(gsel1, a1, b1, rnd_tt);
  assign dut_in0 = gate_fn(gsel0, a0, b0, rnd_tt);

  gate_truth_table_identifier #(.SETTLE_CYCLES(1)) u_dut1 (
    .clk(clk), .rst(rst), .start_in(start1), .dut_in(dut_in1),
    .a_out(a1), .b_out(b1), .busy_out(busy1), .done_out(done1),
    .valid_out(valid1), .gate_code_out(code1), .tt_out(tt1));

  gate_truth_table_identifier #(.SETTLE_CYCLES(0)) u_dut0 (
    .clk(clk), .rst(rst), .start_in(start0), .dut_in(dut_in0),
    .a_out(a0), .b_out(b0), .busy_out(busy0), .done_out(done0),
    .valid_out(valid0), .gate_code_out(code0), .tt_out(tt0));

  always_comb begin
    if (msel == 1) begin
      a_m = a1; b_m = b1; busy_m = busy1; done_m = done1;
      valid_m = valid1; code_m = code1; tt_m = tt1;
    end else begin
      a_m = a0; b_m = b0; busy_m = busy0; done_m = done0;
      valid_m = valid0; code_m = code0; tt_m = tt0;
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  // Reference: evaluate the gate on every vector, then look the table up.
  task automatic model(input int g, input logic [3:0] rt, output logic [3:0] tt,
                       output logic [2:0] code, output logic vld);
    tt = 4'd0; code = 3'd0; vld = 1'b0;
    for (int k = 0; k < 4; k++) tt[k] = gate_fn(g, k[1], k[0], rt);
    for (int k = 0; k < 8; k++)
      if (known[k] == tt) begin code = 3'(k); vld = 1'b1; end
  endtask

  // One complete run on instance sel (1: S=1, 0: S=0) checked cycle by cycle.
  task automatic run_one(input int sel, input logic [3:0] e_tt, input logic [2:0] e_code,
                         input logic e_vld, input string nm);
    int s, n, dn;
    logic [3:0] prev_tt;
    msel = sel;
    s = (sel == 1) ? 1 : 0;
    @(negedge clk);
    prev_tt = tt_m;
    if (sel == 1) start1 = 1'b1; else start0 = 1'b1;
    @(negedge clk);
    start1 = 1'b0; start0 = 1'b0;
    dn = -1; n = 0;
    while (dn < 0 && n < 40) begin
      if (done_m) dn = n;
      else begin
        if (n < 4 * (s + 1)) begin
          chk({nm, "_ab"}, int'({a_m, b_m}), n / (s + 1));
          chk({nm, "_busy"}, int'(busy_m), 1);
          if (n == 0 || n == 4 * (s + 1) - 1) chk({nm, "_hold_tt"}, int'(tt_m), int'(prev_tt));
        end
        @(negedge clk);
        n++;
      end
    end
    chk({nm, "_latency"}, dn, 4 * (s + 1));
    if (dn >= 0) begin
      chk({nm, "_tt"}, int'(tt_m), int'(e_tt));
      chk({nm, "_code"}, int'(code_m), int'(e_code));
      chk({nm, "_valid"}, int'(valid_m), int'(e_vld));
      chk({nm, "_busy_done"}, int'(busy_m), 0);
      chk({nm, "_ab_done"}, int'({a_m, b_m}), 0);
      @(negedge clk);
      chk({nm, "_done_pulse"}, int'(done_m), 0);
    end
  endtask

  typedef struct {
    int         gate;
    logic [3:0] tt;
    logic [2:0] code;
    logic       vld;
  } vec_t;

  vec_t vecs [11];

  initial begin
    logic [3:0] m_tt;
    logic [2:0] m_code;
    logic m_vld;
    int d_first, d_second, d_count;

    vecs[0]  = '{2, 4'b1000, 3'd2, 1'b1};
    vecs[1]  = '{0, 4'b0011, 3'd0, 1'b1};
    vecs[2]  = '{1, 4'b1100, 3'd1, 1'b1};
    vecs[3]  = '{2, 4'b1000, 3'd2, 1'b1};
    vecs[4]  = '{3, 4'b1110, 3'd3, 1'b1};
    vecs[5]  = '{4, 4'b0111, 3'd4, 1'b1};
    vecs[6]  = '{5, 4'b0001, 3'd5, 1'b1};
    vecs[7]  = '{6, 4'b0110, 3'd6, 1'b1};
    vecs[8]  = '{7, 4'b1001, 3'd7, 1'b1};
    vecs[9]  = '{8, 4'b0000, 3'd0, 1'b0};
    vecs[10] = '{9, 4'b1111, 3'd0, 1'b0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ab1", int'({a1, b1}), 0);
    chk("rst_busy1", int'(busy1), 0);
    chk("rst_done1", int'(done1), 0);
    chk("rst_valid1", int'(valid1), 0);
    chk("rst_code1", int'(code1), 0);
    chk("rst_tt1", int'(tt1), 0);
    chk("rst_busy0", int'(busy0), 0);
    chk("rst_tt0", int'(tt0), 0);
    rst = 1'b0;

    for (int i = 0; i < 11; i++) begin
      gsel1 = vecs[i].gate;
      run_one(1, vecs[i].tt, vecs[i].code, vecs[i].vld, $sformatf("vec%0d", i));
    end

    gsel0 = 6;
    run_one(0, 4'b0110, 3'd6, 1'b1, "s0_xor");
    gsel0 = 3;
    run_one(0, 4'b1110, 3'd3, 1'b1, "s0_or");

    for (int i = 0; i < 12; i++) begin
      rnd_tt = 4'($urandom);
      if (i % 3 == 0) rnd_tt = known[$urandom_range(0, 7)];
      model(10, rnd_tt, m_tt, m_code, m_vld);
      if (i % 2 == 0) begin
        gsel1 = 10;
        run_one(1, m_tt, m_code, m_vld, $sformatf("rnd1_%0d", i));
      end else begin
        gsel0 = 10;
        run_one(0, m_tt, m_code, m_vld, $sformatf("rnd0_%0d", i));
      end
    end

    // Extra start pulses while busy must be ignored.
    msel = 1; gsel1 = 3; d_count = 0; d_first = -1;
    @(negedge clk); start1 = 1'b1;
    @(negedge clk); start1 = 1'b0;
    for (int n = 0; n < 16; n++) begin
      if (done1) begin d_count++; if (d_first < 0) d_first = n; end
      if (n == 10) chk("extra_busy_after", int'(busy1), 0);
      start1 = (n == 2 || n == 5) ? 1'b1 : 1'b0;
      @(negedge clk);
    end
    start1 = 1'b0;
    chk("extra_done_count", d_count, 1);
    chk("extra_done_at", d_first, 8);

    // start held high: back-to-back runs one IDLE cycle apart.
    gsel1 = 5; d_first = -1; d_second = -1;
    @(negedge clk); start1 = 1'b1;
    @(negedge clk);
    for (int n = 0; n < 20; n++) begin
      if (done1) begin if (d_first < 0) d_first = n; else d_second = n; end
      if (n == 9)  chk("held_idle_gap", int'(busy1), 0);
      if (n == 10) chk("held_restart", int'(busy1), 1);
      if (n == 19) start1 = 1'b0;
      @(negedge clk);
    end
    chk("held_done1", d_first, 8);
    chk("held_done2", d_second, 18);
    chk("held_tt", int'(tt1), 4'b0001);

    // Reset asserted five cycles into a run.
    gsel1 = 7;
    @(negedge clk); start1 = 1'b1;
    @(negedge clk); start1 = 1'b0;
    for (int n = 0; n < 4; n++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_ab", int'({a1, b1}), 0);
    chk("mid_rst_busy", int'(busy1), 0);
    chk("mid_rst_done", int'(done1), 0);
    chk("mid_rst_valid", int'(valid1), 0);
    chk("mid_rst_code", int'(code1), 0);
    chk("mid_rst_tt", int'(tt1), 0);
    d_count = 0;
    for (int n = 0; n < 12; n++) begin
      if (done1 || busy1) d_count++;
      @(negedge clk);
    end
    chk("mid_rst_no_done", d_count, 0);
    run_one(1, 4'b1001, 3'd7, 1'b1, "after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
